// File: rtl/syn_i2s_adc_rx.sv
// Codec ADC I2S receiver: deserialises BCLK/ADCLRCK/ADCDAT into
// stereo PCM samples delivered over a valid/ready handshake.

package syn_audio_pkg;

    localparam int PCM_DATA_W = 32;

    typedef enum logic {
        BPS_16 = 1'b0,
        BPS_32 = 1'b1
    } bps_t;

    typedef struct packed {
        logic [PCM_DATA_W-1:0] lchnnl;
        logic [PCM_DATA_W-1:0] rchnnl;
    } pcm_data_t;

endpackage

module syn_i2s_adc_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PCM_DATA_W  = 32
) (
    input  logic                    clk_ir,
    input  logic                    rst_ih,
    input  logic                    adc_en_i,
    input  syn_audio_pkg::bps_t     bps_i,
    input  logic                    aud_bclk_i,
    input  logic                    aud_adclrck_i,
    input  logic                    aud_adcdat_i,
    output syn_audio_pkg::pcm_data_t pcm_data_o,
    output logic                    pcm_valid_o,
    input  logic                    pcm_rdy_i,
    output logic                    overrun_o,
    output logic                    frm_err_o,
    input  logic                    ovr_clr_i
);

    localparam int CW = $clog2(PCM_DATA_W + 1);
    localparam int HW = PCM_DATA_W / 2;

    typedef enum logic [2:0] {
        IDLE,
        LSKIP,
        LSHIFT,
        LWAIT,
        RSKIP,
        RSHIFT,
        RWAIT
    } state_t;

    // Synchroniser chains, one per codec input
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_d;

    // Edge detection
    logic bclk_prev_q;
    logic bclk_prev_d;
    logic lrck_last_q;
    logic lrck_last_d;

    // Frame state
    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       bit_cnt_q;
    logic [CW-1:0]       bit_cnt_d;
    syn_audio_pkg::bps_t bps_q;
    syn_audio_pkg::bps_t bps_d;
    logic [PCM_DATA_W-1:0] shift_l_q;
    logic [PCM_DATA_W-1:0] shift_l_d;
    logic [PCM_DATA_W-1:0] shift_r_q;
    logic [PCM_DATA_W-1:0] shift_r_d;

    // Output registers
    syn_audio_pkg::pcm_data_t pcm_data_q;
    syn_audio_pkg::pcm_data_t pcm_data_d;
    logic pcm_valid_q;
    logic pcm_valid_d;
    logic overrun_q;
    logic overrun_d;
    logic frm_err_q;
    logic frm_err_d;

    // Combinational helpers
    logic          bclk_s;
    logic          lrck_s;
    logic          dat_s;
    logic          bclk_rise;
    logic          to_left;
    logic          to_right;
    logic          lr_chg;
    logic [CW-1:0] n_bits;
    logic [CW-1:0] bit_cnt_inc;
    logic          smp_done;
    logic          ovr_set;
    syn_audio_pkg::pcm_data_t smp;

    assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];

    assign bclk_rise = bclk_s & ~bclk_prev_q;
    assign to_left   = lrck_last_q & ~lrck_s;
    assign to_right  = ~lrck_last_q & lrck_s;
    assign lr_chg    = to_left | to_right;

    assign n_bits = (bps_q == syn_audio_pkg::BPS_32)
                  ? CW'(PCM_DATA_W)
                  : CW'(HW);

    assign bit_cnt_inc = bit_cnt_q + CW'(1);

    // Shift codec pins into the synchronisers and track BCLK/LRCK history
    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], aud_bclk_i};
        lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], aud_adclrck_i};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], aud_adcdat_i};
        bclk_prev_d = bclk_s;
        lrck_last_d = bclk_rise ? lrck_s : lrck_last_q;
    end

    // Sign-extend or pass through the assembled channels
    always_comb begin
        if (bps_q == syn_audio_pkg::BPS_32) begin
            smp.lchnnl = shift_l_q;
            smp.rchnnl = shift_r_d;
        end else begin
            smp.lchnnl = {{(PCM_DATA_W-HW){shift_l_q[HW-1]}},
                          shift_l_q[HW-1:0]};
            smp.rchnnl = {{(PCM_DATA_W-HW){shift_r_d[HW-1]}},
                          shift_r_d[HW-1:0]};
        end
    end

    // Frame FSM: skip the LRCK change edge, shift N bits, wait for next channel
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bps_d     = bps_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        frm_err_d = 1'b0;
        smp_done  = 1'b0;
        if (!adc_en_i) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else if (bclk_rise) begin
            unique case (state_q)
                IDLE: begin
                    if (to_left) begin
                        state_d   = LSKIP;
                        bps_d     = bps_i;
                        bit_cnt_d = '0;
                    end
                end
                LSKIP, LSHIFT: begin
                    if (lr_chg) begin
                        frm_err_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = to_left ? LSKIP : IDLE;
                        if (to_left) begin
                            bps_d = bps_i;
                        end
                    end else begin
                        shift_l_d = {shift_l_q[PCM_DATA_W-2:0], dat_s};
                        bit_cnt_d = bit_cnt_inc;
                        if (bit_cnt_inc == n_bits) begin
                            state_d = LWAIT;
                        end else begin
                            state_d = LSHIFT;
                        end
                    end
                end
                LWAIT: begin
                    if (to_right) begin
                        state_d   = RSKIP;
                        bit_cnt_d = '0;
                    end
                end
                RSKIP, RSHIFT: begin
                    if (lr_chg) begin
                        frm_err_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = to_left ? LSKIP : IDLE;
                        if (to_left) begin
                            bps_d = bps_i;
                        end
                    end else begin
                        shift_r_d = {shift_r_q[PCM_DATA_W-2:0], dat_s};
                        bit_cnt_d = bit_cnt_inc;
                        if (bit_cnt_inc == n_bits) begin
                            state_d  = RWAIT;
                            smp_done = 1'b1;
                        end else begin
                            state_d = RSHIFT;
                        end
                    end
                end
                RWAIT: begin
                    if (to_left) begin
                        state_d   = LSKIP;
                        bps_d     = bps_i;
                        bit_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    // Output handshake: load a finished sample or flag it as dropped
    always_comb begin
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = pcm_valid_q;
        ovr_set     = 1'b0;
        if (pcm_valid_q && pcm_rdy_i) begin
            pcm_valid_d = 1'b0;
        end
        if (smp_done) begin
            if (!pcm_valid_q || pcm_rdy_i) begin
                pcm_data_d  = smp;
                pcm_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        overrun_d = ovr_set | (overrun_q & ~ovr_clr_i);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
            lrck_last_q <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            bps_q       <= syn_audio_pkg::BPS_16;
            shift_l_q   <= '0;
            shift_r_q   <= '0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lrck_sync_q <= lrck_sync_d;
            dat_sync_q  <= dat_sync_d;
            bclk_prev_q <= bclk_prev_d;
            lrck_last_q <= lrck_last_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bps_q       <= bps_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
            frm_err_q   <= frm_err_d;
        end
    end

    assign pcm_data_o  = pcm_data_q;
    assign pcm_valid_o = pcm_valid_q;
    assign overrun_o   = overrun_q;
    assign frm_err_o   = frm_err_q;

endmodule
